regbank_arbiter: RTL and testbench

Shares the SPI-configured register bank between the SPI slave write path and NUM_REQ on-chip local requesters. It owns the storage and the single write/read port, and it exposes the flattened config vector to the rest of the design. SPI writes always win because they arrive as single-cycle pulses that cannot be stalled. Local requesters are served round-robin through a req/gnt handshake.

---
 rtl/regbank_arbiter.sv | 156 +++++++++++++++
 tb/tb_regbank_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - shared register bank with SPI-priority writes and round-robin local access (optional REGBANK_LOCK_EN)
module regbank_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [ADDR_W-1:0]           spi_addr,
    input  logic [WIDTH-1:0]            spi_wdata,
    input  logic                        spi_wr_vld,
    output logic [WIDTH-1:0]            spi_rdata,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [WIDTH-1:0]            rdata,
    output logic                        busy,
    output logic [NUM_REGS*WIDTH-1:0]   config_regs
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]   mem [NUM_REGS];
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic               sel_we;
    logic               start;
    logic               do_access;
    logic               lock;

`ifdef REGBANK_LOCK_EN
    assign lock = mem[0][WIDTH-1];
`else
    assign lock = 1'b0;
`endif

    // Round-robin pick: first requester with req high, starting at ptr and wrapping.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Decode the latched requester's fields and the pointer that follows it.
    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
        sel_addr        = addr[int'(sel)*ADDR_W +: ADDR_W];
        sel_wdata       = wdata[int'(sel)*WIDTH +: WIDTH];
        sel_we          = we[sel];
        ptr_next        = (int'(sel) == NUM_REQ - 1) ? '0 : PTR_W'(int'(sel) + 1);
    end

    // Next-state logic; an SPI strobe blocks a new start and stalls an access in flight.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (ena && |req && !spi_wr_vld) begin
                    start      = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!spi_wr_vld) begin
                    do_access  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Storage, handshake outputs and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
            rdata <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            busy <= (next_state != IDLE);
            if (ena && spi_wr_vld) begin
                mem[spi_addr] <= spi_wdata;
            end
            if (start) begin
                sel <= pick;
            end
            if (do_access) begin
                if (sel_we) begin
                    if (!lock) begin
                        mem[sel_addr] <= sel_wdata;
                    end
                end else begin
                    rdata <= mem[sel_addr];
                end
                gnt <= sel_onehot;
                ptr <= ptr_next;
            end
            if (state == DONE) begin
                gnt <= '0;
            end
        end
    end

    // SPI read-back is a plain mux with no latency.
    assign spi_rdata = mem[spi_addr];

    // Flatten storage into the config vector.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign config_regs[g*WIDTH +: WIDTH] = mem[g];
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - directed self-checking bench for regbank_arbiter
module tb_regbank_arbiter;

    localparam int NUM_REGS = 8;
    localparam int WIDTH    = 8;
    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 3;

`ifdef REGBANK_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       ena;
    logic [ADDR_W-1:0]          spi_addr;
    logic [WIDTH-1:0]           spi_wdata;
    logic                       spi_wr_vld;
    logic [WIDTH-1:0]           spi_rdata;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         we;
    logic [NUM_REQ*ADDR_W-1:0]  addr;
    logic [NUM_REQ*WIDTH-1:0]   wdata;
    logic [NUM_REQ-1:0]         gnt;
    logic [WIDTH-1:0]           rdata;
    logic                       busy;
    logic [NUM_REGS*WIDTH-1:0]  config_regs;

    int checks = 0;
    int errors = 0;

    regbank_arbiter #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .NUM_REQ  (NUM_REQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_wr_vld  (spi_wr_vld),
        .spi_rdata   (spi_rdata),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rdata       (rdata),
        .busy        (busy),
        .config_regs (config_regs)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 12);
    endtask

    task automatic test_reset;
        rst = 1'b1; ena = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wr_vld = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %h want 0", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
        checks++; if (config_regs !== 64'h0) begin errors++; $display("FAIL reset_cfg got %h want 0", config_regs); end
    endtask

    task automatic test_spi_write;
        spi_addr = 3'd3; spi_wdata = 8'hA5; spi_wr_vld = 1'b1;
        tick();
        spi_wr_vld = 1'b0;
        checks++; if (config_regs[31:24] !== 8'hA5) begin errors++; $display("FAIL spi_cfg3 got %h want a5", config_regs[31:24]); end
        checks++; if (spi_rdata !== 8'hA5) begin errors++; $display("FAIL spi_rdata got %h want a5", spi_rdata); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL spi_gnt got %h want 0", gnt); end
    endtask

    task automatic test_local_write;
        req = 2'b01; we = 2'b01; addr[2:0] = 3'd5; wdata[7:0] = 8'h3C;
        tick();
        checks++; if (busy !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL lw_access busy=%b gnt=%h want 1/0", busy, gnt); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL lw_gnt got %h want 01", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lw_busy_done got %b want 1", busy); end
        checks++; if (config_regs[47:40] !== 8'h3C) begin errors++; $display("FAIL lw_mem5 got %h want 3c", config_regs[47:40]); end
        req = 2'b00;
        tick();
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL lw_end gnt=%h busy=%b want 0/0", gnt, busy); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g [4];
        logic [7:0] exp_d [4];
        int n;
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        exp_d[0] = 8'hA5; exp_d[1] = 8'h3C; exp_d[2] = 8'hA5; exp_d[3] = 8'h3C;
        we = 2'b00; addr[2:0] = 3'd5; addr[5:3] = 3'd3; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            checks++; if (n !== ((k == 0) ? 2 : 3)) begin errors++; $display("FAIL rr_spacing_%0d got %0d want %0d", k, n, (k == 0) ? 2 : 3); end
            checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL rr_gnt_%0d got %h want %h", k, gnt, exp_g[k]); end
            checks++; if (rdata !== exp_d[k]) begin errors++; $display("FAIL rr_rdata_%0d got %h want %h", k, rdata, exp_d[k]); end
        end
        req = 2'b00;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy got %b want 0", busy); end
    endtask

    task automatic test_spi_stall;
        req = 2'b10; we = 2'b00; addr[5:3] = 3'd2;
        tick();
        spi_addr = 3'd2; spi_wdata = 8'h77; spi_wr_vld = 1'b1;
        tick();
        spi_wr_vld = 1'b0;
        checks++; if (gnt !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL stall gnt=%h busy=%b want 0/1", gnt, busy); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL stall_gnt got %h want 10", gnt); end
        checks++; if (rdata !== 8'h77) begin errors++; $display("FAIL stall_rdata got %h want 77", rdata); end
        req = 2'b00;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL stall_end got %h want 0", gnt); end
    endtask

    task automatic test_reset_mid;
        req = 2'b01; we = 2'b01; addr[2:0] = 3'd6; wdata[7:0] = 8'h55;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_access busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 2'b00;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rm_gnt got %h want 0", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
        checks++; if (config_regs !== 64'h0) begin errors++; $display("FAIL rm_cfg got %h want 0", config_regs); end
        tick();
        checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rm_after gnt=%h busy=%b want 0/0", gnt, busy); end
    endtask

    task automatic test_ena_low;
        ena = 1'b0;
        spi_addr = 3'd4; spi_wdata = 8'h99; spi_wr_vld = 1'b1;
        req = 2'b01; we = 2'b00; addr[2:0] = 3'd4;
        tick();
        spi_wr_vld = 1'b0;
        checks++; if (config_regs[39:32] !== 8'h00) begin errors++; $display("FAIL ena_spi got %h want 00", config_regs[39:32]); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL ena_idle_%0d gnt=%h busy=%b want 0/0", k, gnt, busy); end
        end
        ena = 1'b1; spi_wdata = 8'h5A; spi_wr_vld = 1'b1;
        tick();
        spi_wr_vld = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_spi_block busy got %b want 0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ena_start busy got %b want 1", busy); end
        tick();
        checks++; if (gnt !== 2'b01 || rdata !== 8'h5A) begin errors++; $display("FAIL ena_read gnt=%h rdata=%h want 01/5a", gnt, rdata); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_lock;
        int n;
        spi_addr = 3'd0; spi_wdata = 8'h80; spi_wr_vld = 1'b1;
        tick();
        spi_wr_vld = 1'b0;
        req = 2'b01; we = 2'b01; addr[2:0] = 3'd1; wdata[7:0] = 8'h11;
        wait_gnt(n);
        checks++; if (gnt !== 2'b01 || n !== 2) begin errors++; $display("FAIL lock_gnt got %h after %0d want 01 after 2", gnt, n); end
        checks++; if (config_regs[15:8] !== (LOCK_ON ? 8'h00 : 8'h11)) begin errors++; $display("FAIL lock_mem1 got %h want %h", config_regs[15:8], LOCK_ON ? 8'h00 : 8'h11); end
        req = 2'b00;
        tick();
        spi_wdata = 8'h00; spi_wr_vld = 1'b1;
        tick();
        spi_wr_vld = 1'b0;
        req = 2'b01;
        wait_gnt(n);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL unlock_gnt got %h want 01", gnt); end
        checks++; if (config_regs[15:8] !== 8'h11) begin errors++; $display("FAIL unlock_mem1 got %h want 11", config_regs[15:8]); end
        spi_addr = 3'd1;
        checks++; if (spi_rdata !== 8'h11) begin errors++; $display("FAIL unlock_spi_rdata got %h want 11", spi_rdata); end
        req = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_local_write();
        test_round_robin();
        test_spi_stall();
        test_reset_mid();
        test_ena_low();
        test_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
